// File: rtl/dense_seq_pkg.sv
// dense_seq_pkg: shared state encoding and backprop control field positions
package dense_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD_W, FWD, COST, BWD, DONE} state_t;
  localparam int BP_EN_BIT   = 65;
  localparam int BP_LAST_BIT = 64;
  localparam int BP_LR_MSB   = 63;
  localparam int BP_LR_LSB   = 32;
  localparam int BP_STEP_MSB = 31;
  localparam int BP_STEP_LSB = 0;
endpackage

// File: rtl/dense_layer_table.sv
// dense_layer_table: per-layer descriptor register file, one write port, async read
module dense_layer_table #(
  parameter int num_layers = 4,
  parameter int idx_w      = 2,
  parameter int act_w      = 4,
  parameter int dense_w    = 4,
  parameter int cnt_w      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [idx_w-1:0]   waddr,
  input  logic [act_w-1:0]   wact,
  input  logic [dense_w-1:0] wdense,
  input  logic [cnt_w-1:0]   wwords,
  input  logic [idx_w-1:0]   raddr,
  output logic [act_w-1:0]   ract,
  output logic [dense_w-1:0] rdense,
  output logic [cnt_w-1:0]   rwords
);
  logic [act_w-1:0]   act   [num_layers];
  logic [dense_w-1:0] dense [num_layers];
  logic [cnt_w-1:0]   words [num_layers];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < num_layers; i++) begin
        act[i]   <= '0;
        dense[i] <= '0;
        words[i] <= '0;
      end
    else if (we) begin
      act[waddr]   <= wact;
      dense[waddr] <= wdense;
      words[waddr] <= wwords;
    end
  assign ract   = act[raddr];
  assign rdense = dense[raddr];
  assign rwords = words[raddr];
endmodule

// File: rtl/dense_seq_ctrl.sv
// dense_seq_ctrl: sequences weight load, forward, cost and backward issues into the dense pipeline
module dense_seq_ctrl
  import dense_seq_pkg::*;
#(
  parameter int size                   = 3,
  parameter int data_size              = 16,
  parameter int act_type_size          = 4,
  parameter int dense_type_size        = 4,
  parameter int cost_type_size         = 8,
  parameter int num_layers             = 4,
  parameter int layer_idx_size         = 2,
  parameter int w_cnt_size             = 8,
  parameter int layer_latency          = 4,
  parameter int backprop_controll_size = 66
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cfg_we,
  input  logic [layer_idx_size-1:0]         cfg_addr,
  input  logic [act_type_size-1:0]          cfg_act_type,
  input  logic [dense_type_size-1:0]        cfg_dense_type,
  input  logic [w_cnt_size-1:0]             cfg_w_words,
  input  logic [cost_type_size-1:0]         cost_type,
  input  logic [31:0]                       lr,
  input  logic                              start,
  input  logic                              train,
  input  logic                              abort,
  input  logic [data_size*size-1:0]         w_in,
  input  logic                              w_valid,
  output logic                              w_ready,
  input  logic [data_size*size-1:0]         x_in,
  input  logic                              x_valid,
  output logic                              x_ready,
  input  logic [data_size*size-1:0]         label_in,
  input  logic                              label_valid,
  output logic                              label_ready,
  output logic [act_type_size-1:0]          act_type_out,
  output logic [dense_type_size-1:0]        dense_type_out,
  output logic [cost_type_size-1:0]         cost_type_out,
  output logic [data_size*size-1:0]         w_out,
  output logic                              load_w_out,
  output logic [data_size*size-1:0]         x_out,
  output logic [data_size*size-1:0]         label_out,
  output logic [backprop_controll_size-1:0] backprop_controll_out,
  output logic [layer_idx_size-1:0]         layer_idx_out,
  output logic                              pipe_valid,
  output logic                              busy,
  output logic                              done
);
  localparam int gap_w = $clog2(layer_latency) + 1;
  state_t                      state, nxt;
  logic [layer_idx_size-1:0]   layer;
  logic [w_cnt_size-1:0]       cnt;
  logic [gap_w-1:0]            gap;
  logic                        train_r;
  logic [cost_type_size-1:0]   cost_r;
  logic [31:0]                 lr_r, step;
  logic [act_type_size-1:0]    t_act;
  logic [dense_type_size-1:0]  t_dense;
  logic [w_cnt_size-1:0]       t_words;
  logic w_acc, l_acc, fwd_go, bwd_go, issue, last_layer, layer_adv, start_go, done_go, tbl_we;
  dense_layer_table #(
    .num_layers(num_layers), .idx_w(layer_idx_size), .act_w(act_type_size),
    .dense_w(dense_type_size), .cnt_w(w_cnt_size)
  ) u_table (
    .clk(clk), .rst_n(rst_n), .we(tbl_we), .waddr(cfg_addr), .wact(cfg_act_type),
    .wdense(cfg_dense_type), .wwords(cfg_w_words), .raddr(layer),
    .ract(t_act), .rdense(t_dense), .rwords(t_words)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    case (state)
      IDLE:    nxt = start ? LOAD_W : IDLE;
      LOAD_W:  nxt = layer_adv && last_layer ? FWD : LOAD_W;
      FWD:     nxt = fwd_go && last_layer ? (train_r ? COST : DONE) : FWD;
      COST:    nxt = l_acc ? BWD : COST;
      BWD:     nxt = bwd_go && layer == '0 ? DONE : BWD;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_comb begin
    busy        = state != IDLE;
    w_ready     = state == LOAD_W && cnt != t_words;
    x_ready     = state == FWD && layer == '0;
    label_ready = state == COST;
    last_layer  = layer == layer_idx_size'(num_layers - 1);
    w_acc       = w_valid && w_ready && !abort;
    l_acc       = label_valid && label_ready && !abort;
    fwd_go      = state == FWD && !abort && (layer == '0 ? x_valid : gap == '0);
    bwd_go      = state == BWD && !abort && gap == '0;
    layer_adv   = state == LOAD_W && !abort && (t_words == '0 || (w_acc && w_cnt_size'(cnt + 1) == t_words));
    issue       = w_acc || fwd_go || l_acc || bwd_go;
    start_go    = state == IDLE && start && !abort;
    done_go     = state == DONE && !abort;
    tbl_we      = state == IDLE && cfg_we && !abort;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      layer <= '0; cnt <= '0; gap <= '0; train_r <= 1'b0; cost_r <= '0; lr_r <= '0; step <= '0;
      act_type_out <= '0; dense_type_out <= '0; cost_type_out <= '0; w_out <= '0;
      load_w_out <= 1'b0; x_out <= '0; label_out <= '0; backprop_controll_out <= '0;
      layer_idx_out <= '0; pipe_valid <= 1'b0; done <= 1'b0;
    end else begin
      pipe_valid <= issue;
      load_w_out <= w_acc;
      done       <= done_go;
      backprop_controll_out[BP_EN_BIT]   <= bwd_go;
      backprop_controll_out[BP_LAST_BIT] <= bwd_go && layer == '0;
      if (issue) begin
        layer_idx_out <= layer;
        backprop_controll_out[BP_LR_MSB:BP_STEP_LSB] <= {lr_r, step};
      end
      if (w_acc) w_out <= w_in;
      if (fwd_go || bwd_go) begin
        act_type_out   <= t_act;
        dense_type_out <= t_dense;
      end
      if (fwd_go) x_out <= layer == '0 ? x_in : '0;
      if (l_acc) begin
        label_out     <= label_in;
        cost_type_out <= cost_r;
      end
      // spacing counter restarts on every issue so each layer follows its predecessor
      gap <= issue ? gap_w'(layer_latency - 1) : (gap == '0 ? gap : gap_w'(gap - 1));
      if (start_go) begin
        layer <= '0; cnt <= '0; train_r <= train; cost_r <= cost_type; lr_r <= lr;
      end
      if (layer_adv) begin
        cnt   <= '0;
        layer <= last_layer ? '0 : layer_idx_size'(layer + 1);
      end else if (w_acc) cnt <= w_cnt_size'(cnt + 1);
      if (fwd_go && !last_layer) layer <= layer_idx_size'(layer + 1);
      if (l_acc) layer <= layer_idx_size'(num_layers - 1);
      if (bwd_go && layer != '0) layer <= layer_idx_size'(layer - 1);
      if (done_go) step <= step + 32'(train_r);
    end
endmodule
